control_axil_regs: RTL and testbench

AXI4-Lite slave register file implementing the `S00_AXI` control window of the control IP. The master BFM writes and reads it through the block design. Four 32-bit control registers at offsets 0x0, 0x4, 0x8 and 0xC are driven out to fabric, each with a one-cycle write strobe. The block sits directly downstream of the AXI master and upstream of the control datapath.

---
 rtl/control_pkg.sv | 45 ++++
 rtl/control_axil_wr_ctrl.sv | 96 +++++++++
 rtl/control_axil_regs.sv | 118 +++++++++++
 tb/tb_control_axil_regs.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types, register map and helpers for the control AXI4-Lite register window.
// Optional build macro: CONTROL_ADDR_DECERR_EN (DECERR on accesses to unimplemented words).
package control_pkg;

    localparam int unsigned CTRL_REG0 = 0;
    localparam int unsigned CTRL_REG1 = 1;
    localparam int unsigned CTRL_REG2 = 2;
    localparam int unsigned CTRL_REG3 = 3;

    localparam int unsigned C_NUM_REGS_DEF = 4;
    localparam int unsigned REG_W          = 32;
    localparam int unsigned STRB_W         = REG_W / 8;

`ifdef CONTROL_ADDR_DECERR_EN
    localparam bit ADDR_DECERR_EN = 1'b1;
`else
    localparam bit ADDR_DECERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef logic [C_NUM_REGS_DEF-1:0][REG_W-1:0] ctrl_regs_t;

    // Response code for an access; misses only error out when decode errors are enabled.
    function automatic axi_resp_e access_resp(input logic hit);
        return (!hit && ADDR_DECERR_EN) ? DECERR : OKAY;
    endfunction

    function automatic logic [REG_W-1:0] apply_wstrb(input logic [REG_W-1:0]  old_val,
                                                     input logic [REG_W-1:0]  new_val,
                                                     input logic [STRB_W-1:0] strb);
        logic [REG_W-1:0] res;
        res = old_val;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/control_axil_wr_ctrl.sv
// AXI4-Lite write side: independent AW/W holding slots, commit strobe and B channel.
// Response code for unimplemented words follows CONTROL_ADDR_DECERR_EN via control_pkg.
module control_axil_wr_ctrl
    import control_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = C_NUM_REGS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    aw_idx,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_valid,
    output logic                w_ready,
    output logic [1:0]          b_resp,
    output logic                b_valid,
    input  logic                b_ready,
    output logic                commit_c,
    output logic [IDX_W-1:0]    commit_idx,
    output logic [DATA_W-1:0]   commit_data,
    output logic [DATA_W/8-1:0] commit_strb
);

    logic                aw_full, aw_full_d;
    logic                w_full, w_full_d;
    logic [IDX_W-1:0]    idx_d;
    logic [DATA_W-1:0]   data_d;
    logic [DATA_W/8-1:0] strb_d;
    logic                b_valid_d, aw_ready_d, w_ready_d;
    axi_resp_e           b_resp_q, b_resp_d;

    assign commit_c = aw_full & w_full;
    assign b_resp   = b_resp_q;

    // Next-state: slots fill on handshake, drain together on commit.
    always_comb begin
        aw_full_d  = aw_full;
        w_full_d   = w_full;
        idx_d      = commit_idx;
        data_d     = commit_data;
        strb_d     = commit_strb;
        b_valid_d  = b_valid;
        b_resp_d   = b_resp_q;

        if (aw_valid && aw_ready) begin
            aw_full_d = 1'b1;
            idx_d     = aw_idx;
        end
        if (w_valid && w_ready) begin
            w_full_d = 1'b1;
            data_d   = w_data;
            strb_d   = w_strb;
        end

        if (commit_c) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = access_resp(32'(commit_idx) < NUM_REGS);
        end else if (b_valid && b_ready) begin
            b_valid_d = 1'b0;
        end

        aw_ready_d = !aw_full_d && !b_valid_d;
        w_ready_d  = !w_full_d && !b_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            commit_idx  <= '0;
            commit_data <= '0;
            commit_strb <= '0;
            b_valid     <= 1'b0;
            b_resp_q    <= OKAY;
            aw_ready    <= 1'b0;
            w_ready     <= 1'b0;
        end else begin
            aw_full     <= aw_full_d;
            w_full      <= w_full_d;
            commit_idx  <= idx_d;
            commit_data <= data_d;
            commit_strb <= strb_d;
            b_valid     <= b_valid_d;
            b_resp_q    <= b_resp_d;
            aw_ready    <= aw_ready_d;
            w_ready     <= w_ready_d;
        end
    end

endmodule

// File: rtl/control_axil_regs.sv
// AXI4-Lite S00_AXI control window: four 32-bit registers with per-register write pulses.
// Build with CONTROL_ADDR_DECERR_EN to answer unimplemented words with DECERR instead of OKAY.
module control_axil_regs
    import control_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_NUM_REGS         = C_NUM_REGS_DEF
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
    output logic [C_NUM_REGS-1:0]             ctrl_wr_pulse
);

    localparam int unsigned IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic                          commit_c;
    logic [IDX_W-1:0]              commit_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]             commit_strb;
    logic [IDX_W-1:0]              ar_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word_c;
    logic                          rd_hit_c;
    logic                          unused_bits;

    // Byte lane bits and PROT carry no meaning for this register file.
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    control_axil_wr_ctrl #(
        .IDX_W    (IDX_W),
        .DATA_W   (C_S_AXI_DATA_WIDTH),
        .NUM_REGS (C_NUM_REGS)
    ) u_wr_ctrl (
        .clk         (ACLK),
        .rst         (ARESET),
        .aw_idx      (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .aw_valid    (S_AXI_AWVALID),
        .aw_ready    (S_AXI_AWREADY),
        .w_data      (S_AXI_WDATA),
        .w_strb      (S_AXI_WSTRB),
        .w_valid     (S_AXI_WVALID),
        .w_ready     (S_AXI_WREADY),
        .b_resp      (S_AXI_BRESP),
        .b_valid     (S_AXI_BVALID),
        .b_ready     (S_AXI_BREADY),
        .commit_c    (commit_c),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    // Register array and commit pulses; misses fall through untouched.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ctrl_reg      <= '0;
            ctrl_wr_pulse <= '0;
        end else begin
            ctrl_wr_pulse <= '0;
            for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
                if (commit_c && 32'(commit_idx) == i) begin
                    ctrl_reg[i]      <= apply_wstrb(ctrl_reg[i], commit_data, commit_strb);
                    ctrl_wr_pulse[i] <= 1'b1;
                end
            end
        end
    end

    // Read mux sees pre-commit contents, so a same-edge collision returns the old value.
    always_comb begin
        rd_word_c = '0;
        rd_hit_c  = 32'(ar_idx) < C_NUM_REGS;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (32'(ar_idx) == i) rd_word_c = ctrl_reg[i];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'(OKAY);
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_word_c;
            S_AXI_RRESP   <= 2'(access_resp(rd_hit_c));
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
        end else begin
            S_AXI_ARREADY <= !S_AXI_RVALID;
        end
    end

endmodule

// File: tb/tb_control_axil_regs.sv
// Directed self-checking bench for control_axil_regs (honours CONTROL_ADDR_DECERR_EN).
module tb_control_axil_regs;
    import control_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [5:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [5:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    ctrl_regs_t  ctrl_reg;
    logic [3:0]  ctrl_wr_pulse;

    int tests_run = 0;
    int tests_failed = 0;
    int pulse_cnt [4];

    control_axil_regs dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ctrl_reg      (ctrl_reg),
        .ctrl_wr_pulse (ctrl_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        for (int i = 0; i < 4; i++) if (ctrl_wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    end

    task automatic clear_pulses();
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    endtask

    // Presents AW and W after independent delays (in cycles); returns at the negedge after both handshakes.
    task automatic drive_aw_w(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int aw_delay, input int w_delay, output logic ok);
        logic aw_done, w_done, aw_hit, w_hit;
        int c;
        aw_done = 1'b0; w_done = 1'b0; c = 0;
        while ((!aw_done || !w_done) && c < 40) begin
            if (!aw_done && c == aw_delay) begin S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1; end
            if (!w_done && c == w_delay) begin
                S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
            end
            aw_hit = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hit  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK); c++;
            if (aw_hit) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hit)  begin S_AXI_WVALID = 1'b0;  w_done = 1'b1;  end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        ok = aw_done && w_done;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic ok);
        int c;
        c = 0;
        S_AXI_BREADY = 1'b1;
        while (S_AXI_BVALID !== 1'b1 && c < 20) begin @(negedge ACLK); c++; end
        ok = (S_AXI_BVALID === 1'b1);
        resp = S_AXI_BRESP;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output logic lat_ok, output logic ok);
        logic hit;
        int c;
        hit = 1'b0; c = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        while (!hit && c < 40) begin hit = (S_AXI_ARREADY === 1'b1); @(negedge ACLK); c++; end
        S_AXI_ARVALID = 1'b0;
        ok = hit;
        lat_ok = (S_AXI_RVALID === 1'b1);
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge ACLK);
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP,
             S_AXI_RRESP, S_AXI_RDATA, ctrl_reg, ctrl_wr_pulse} !== '0) begin
            tests_failed++; $display("FAIL reset_outputs: got nonzero outputs, regs=%h, required all 0", ctrl_reg);
        end
        ARESET = 1'b0;
        #1;
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            tests_failed++; $display("FAIL ready_before_edge: got %b required 000",
                                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        @(negedge ACLK);
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            tests_failed++; $display("FAIL ready_after_edge: got %b required 111",
                                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_seq_rw();
        int unsigned ids [4];
        logic ok, lat_ok;
        logic [1:0] resp;
        logic [31:0] data;
        ids = '{CTRL_REG0, CTRL_REG1, CTRL_REG2, CTRL_REG3};
        clear_pulses();
        for (int i = 0; i < 4; i++) begin
            drive_aw_w(6'(ids[i] * 4), 32'(i + 1), 4'hF, 0, 0, ok);
            wait_b(resp, ok);
            tests_run++;
            if (!ok || resp !== 2'b00) begin
                tests_failed++; $display("FAIL seq_bresp[%0d]: got ok=%0b resp=%b required ok=1 resp=00", i, ok, resp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(6'(ids[i] * 4), data, resp, lat_ok, ok);
            tests_run++;
            if (!ok || !lat_ok || data !== 32'(i + 1) || resp !== 2'b00) begin
                tests_failed++; $display("FAIL seq_read[%0d]: got ok=%0b lat=%0b data=%h resp=%b required data=%h resp=00",
                                         i, ok, lat_ok, data, resp, 32'(i + 1));
            end
        end
        tests_run++;
        if (pulse_cnt[0] != 1 || pulse_cnt[1] != 1 || pulse_cnt[2] != 1 || pulse_cnt[3] != 1) begin
            tests_failed++; $display("FAIL seq_pulses: got %0d %0d %0d %0d required 1 1 1 1",
                                     pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
    endtask

    task automatic test_aw_w_order();
        logic ok, lat_ok;
        logic [1:0] resp;
        logic [31:0] data;
        logic [31:0] vals [2];
        vals = '{32'hDEADBEEF, 32'h0BADF00D};
        for (int k = 0; k < 2; k++) begin
            // k=0: W leads AW by 3 cycles; k=1: AW leads W by 3 cycles
            if (k == 0) drive_aw_w(6'h04, vals[k], 4'hF, 3, 0, ok);
            else        drive_aw_w(6'h04, vals[k], 4'hF, 0, 3, ok);
            tests_run++;
            if (!ok || S_AXI_BVALID !== 1'b0) begin
                tests_failed++; $display("FAIL order%0d_bvalid_early: got ok=%0b bvalid=%b required bvalid=0", k, ok, S_AXI_BVALID);
            end
            @(negedge ACLK);
            tests_run++;
            if (S_AXI_BVALID !== 1'b1 || ctrl_reg[1] !== vals[k]) begin
                tests_failed++; $display("FAIL order%0d_commit: got bvalid=%b reg1=%h required bvalid=1 reg1=%h",
                                         k, S_AXI_BVALID, ctrl_reg[1], vals[k]);
            end
            wait_b(resp, ok);
            do_read(6'h07, data, resp, lat_ok, ok);
            tests_run++;
            if (!ok || data !== vals[k] || resp !== 2'b00) begin
                tests_failed++; $display("FAIL order%0d_read: got data=%h resp=%b required %h 00", k, data, resp, vals[k]);
            end
        end
    endtask

    task automatic test_byte_strobe();
        logic ok, lat_ok;
        logic [1:0] resp;
        logic [31:0] data;
        drive_aw_w(6'h00, 32'h11223344, 4'hF, 0, 0, ok);
        wait_b(resp, ok);
        drive_aw_w(6'h00, 32'hAABBCCDD, 4'b0101, 0, 0, ok);
        wait_b(resp, ok);
        do_read(6'h00, data, resp, lat_ok, ok);
        tests_run++;
        if (!ok || data !== 32'h11BB33DD) begin
            tests_failed++; $display("FAIL byte_strobe: got %h required 11bb33dd", data);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        logic [1:0] resp;
        int c;
        drive_aw_w(6'h08, 32'h12345678, 4'hF, 0, 0, ok);
        @(negedge ACLK);
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
                tests_failed++; $display("FAIL bp_hold[%0d]: got bvalid/awready/wready=%b required 100",
                                         i, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
            end
            @(negedge ACLK);
        end
        wait_b(resp, ok);
        tests_run++;
        if (!ok || resp !== 2'b00 || {S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11 || ctrl_reg[2] !== 32'h12345678) begin
            tests_failed++; $display("FAIL bp_release: got ok=%0b resp=%b readies=%b reg2=%h required 1 00 11 12345678",
                                     ok, resp, {S_AXI_AWREADY, S_AXI_WREADY}, ctrl_reg[2]);
        end
        // Read reg3 while RREADY is held low
        S_AXI_ARADDR = 6'h0C; S_AXI_ARVALID = 1'b1; c = 0;
        while (S_AXI_ARREADY !== 1'b1 && c < 20) begin @(negedge ACLK); c++; end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h4) begin
                tests_failed++; $display("FAIL bp_rdata[%0d]: got rvalid=%b rdata=%h required 1 00000004", i, S_AXI_RVALID, S_AXI_RDATA);
            end
            @(negedge ACLK);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        tests_run++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            tests_failed++; $display("FAIL bp_rrelease: got rvalid=%b arready=%b required 0 1", S_AXI_RVALID, S_AXI_ARREADY);
        end
    endtask

    task automatic test_unimplemented();
        logic ok, lat_ok;
        logic [1:0] resp, exp_resp;
        logic [31:0] data;
        ctrl_regs_t exp_regs;
`ifdef CONTROL_ADDR_DECERR_EN
        exp_resp = 2'b11;
`else
        exp_resp = 2'b00;
`endif
        exp_regs = {32'h00000004, 32'h12345678, 32'h0BADF00D, 32'h11BB33DD};
        clear_pulses();
        drive_aw_w(6'h20, 32'hFFFFFFFF, 4'hF, 0, 0, ok);
        wait_b(resp, ok);
        tests_run++;
        if (!ok || resp !== exp_resp) begin
            tests_failed++; $display("FAIL unimpl_bresp: got ok=%0b resp=%b required %b", ok, resp, exp_resp);
        end
        do_read(6'h20, data, resp, lat_ok, ok);
        tests_run++;
        if (!ok || data !== 32'h0 || resp !== exp_resp) begin
            tests_failed++; $display("FAIL unimpl_read: got data=%h resp=%b required 00000000 %b", data, resp, exp_resp);
        end
        tests_run++;
        if (ctrl_reg !== exp_regs || (pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]) != 0) begin
            tests_failed++; $display("FAIL unimpl_regs: got %h required %h", ctrl_reg, exp_regs);
        end
    endtask

    task automatic test_reset_mid();
        logic ok, lat_ok;
        logic [1:0] resp;
        logic [31:0] data;
        drive_aw_w(6'h00, 32'h99, 4'hF, 0, 0, ok);
        @(negedge ACLK);
        tests_run++;
        if (S_AXI_BVALID !== 1'b1 || ctrl_reg[0] !== 32'h99) begin
            tests_failed++; $display("FAIL mid_pending: got bvalid=%b reg0=%h required 1 00000099", S_AXI_BVALID, ctrl_reg[0]);
        end
        ARESET = 1'b1;
        #1;
        tests_run++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP,
             S_AXI_RRESP, S_AXI_RDATA, ctrl_reg, ctrl_wr_pulse} !== '0) begin
            tests_failed++; $display("FAIL mid_async_clear: got bvalid=%b regs=%h required all 0", S_AXI_BVALID, ctrl_reg);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        drive_aw_w(6'h08, 32'h5, 4'hF, 0, 0, ok);
        wait_b(resp, ok);
        tests_run++;
        if (!ok || resp !== 2'b00) begin
            tests_failed++; $display("FAIL mid_write: got ok=%0b resp=%b required 1 00", ok, resp);
        end
        do_read(6'h08, data, resp, lat_ok, ok);
        tests_run++;
        if (!ok || data !== 32'h5 || resp !== 2'b00) begin
            tests_failed++; $display("FAIL mid_read: got data=%h resp=%b required 00000005 00", data, resp);
        end
        do_read(6'h00, data, resp, lat_ok, ok);
        tests_run++;
        if (!ok || data !== 32'h0) begin
            tests_failed++; $display("FAIL mid_reg0_cleared: got %h required 00000000", data);
        end
    endtask

    initial begin
        clear_pulses();
        test_reset();
        test_seq_rw();
        test_aw_w_order();
        test_byte_strobe();
        test_backpressure();
        test_unimplemented();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
